online_adder_stream: RTL and testbench

- Radix-2 signed-digit online adder that takes two MSD-first digit streams and returns their sum MSD-first.
- Parametrised successor of the fixed-width online adder, with a configurable operand length (DIGITS).
- Adds valid/ready handshakes on both operand channels and the result channel, framing with a last flag, and automatic flush of the final digits.
- Sits between online operand sources (e.g. Newton iteration stages) and downstream online multipliers/dividers.

---
 rtl/online_pkg.sv | 34 +++
 rtl/online_adder_stream_if.sv | 26 ++
 rtl/online_tw_sel.sv | 41 ++++
 rtl/online_adder_stream.sv | 132 +++++++++++++
 tb/tb_online_adder_stream.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/online_pkg.sv
// Shared digit encoding, conversion helpers and FSM state type for the
// radix-2 signed-digit online adder.
package online_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b01;
  localparam logic [1:0] SD_NEG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // 2'b11 is a redundant zero and decodes the same as 2'b00.
  function automatic logic signed [1:0] sd_decode(input logic [1:0] d);
    case (d)
      SD_POS:  sd_decode = 2'sb01;
      SD_NEG:  sd_decode = 2'sb11;
      default: sd_decode = 2'sb00;
    endcase
  endfunction

  function automatic logic [1:0] sd_encode(input logic signed [1:0] v);
    if (v > 2'sb00) begin
      sd_encode = SD_POS;
    end else if (v < 2'sb00) begin
      sd_encode = SD_NEG;
    end else begin
      sd_encode = SD_ZERO;
    end
  endfunction

endpackage

// File: rtl/online_adder_stream_if.sv
// Operand and result streams of the online adder.
// Handshake: a transfer happens on a rising clk edge where vld and rdy are both
// high; a source holds vld and data stable until that edge and never derives
// vld from rdy.
interface online_adder_stream_if;
  logic [1:0] x_in;
  logic       data_x_vld;
  logic       data_x_rdy;
  logic [1:0] y_in;
  logic       data_y_vld;
  logic       data_y_rdy;
  logic [1:0] data_out;
  logic       data_out_vld;
  logic       data_out_rdy;
  logic       data_out_last;

  modport slave (
    input  x_in, data_x_vld, y_in, data_y_vld, data_out_rdy,
    output data_x_rdy, data_y_rdy, data_out, data_out_vld, data_out_last
  );

  modport master (
    output x_in, data_x_vld, y_in, data_y_vld, data_out_rdy,
    input  data_x_rdy, data_y_rdy, data_out, data_out_vld, data_out_last
  );
endinterface

// File: rtl/online_tw_sel.sv
// Splits a digit-pair sum p_j into transfer t_j and interim w_j
// (p_j = 2*t_j + w_j), looking one position ahead at p_{j+1}.
module online_tw_sel (
  input  logic signed [2:0] p_cur,
  input  logic signed [2:0] p_next,
  output logic signed [1:0] t,
  output logic signed [1:0] w
);

  always_comb begin
    t = 2'sb00;
    w = 2'sb00;
    case (p_cur)
      3'b010: t = 2'sb01;
      3'b110: t = 2'sb11;
      // +/-1 pushes the transfer toward the sign of the next sum so that
      // w_j + t_{j+1} never leaves {-1,0,1}.
      3'b001: begin
        if (p_next >= 3'sb000) begin
          t = 2'sb01;
          w = 2'sb11;
        end else begin
          w = 2'sb01;
        end
      end
      3'b111: begin
        if (p_next <= 3'sb000) begin
          t = 2'sb11;
          w = 2'sb01;
        end else begin
          w = 2'sb11;
        end
      end
      default: begin
        t = 2'sb00;
        w = 2'sb00;
      end
    endcase
  end

endmodule

// File: rtl/online_adder_stream.sv
// Streaming radix-2 signed-digit online adder, MSD first, online delay 2,
// with valid/ready on both operand channels and the result channel.
module online_adder_stream
  import online_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  online_adder_stream_if.slave bus,
  output logic                 busy,
  output state_e               state_dbg
);

  localparam int CNT_W = $clog2(DIGITS + 3);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_END      = CNT_W'(DIGITS + 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic signed [2:0] p_prev2;
  logic signed [2:0] p_prev1;
  logic signed [2:0] p_new;
  logic signed [2:0] p_in;
  logic signed [1:0] x_val;
  logic signed [1:0] y_val;
  logic signed [1:0] w_k;
  logic signed [1:0] t_k1;
  logic signed [1:0] t_unused;
  logic signed [1:0] w_unused;
  logic signed [1:0] z_sum;
  logic              out_free;
  logic              acc;
  logic              fire;
  logic              flush_step;
  logic              emit;

  assign x_val = sd_decode(bus.x_in);
  assign y_val = sd_decode(bus.y_in);
  assign p_new = {x_val[1], x_val} + {y_val[1], y_val};
  // While flushing, the operand positions past DIGITS are implicit zeros.
  assign p_in  = (state == ST_FLUSH) ? 3'sb000 : p_new;

  online_tw_sel u_sel_w (
    .p_cur  (p_prev2),
    .p_next (p_prev1),
    .t      (t_unused),
    .w      (w_k)
  );

  online_tw_sel u_sel_t (
    .p_cur  (p_prev1),
    .p_next (p_in),
    .t      (t_k1),
    .w      (w_unused)
  );

  assign z_sum = w_k + t_k1;

  assign out_free   = !bus.data_out_vld || bus.data_out_rdy;
  assign acc        = !asyn_reset && ((state == ST_IDLE) || (state == ST_RUN)) && out_free;
  assign fire       = acc && bus.data_x_vld && bus.data_y_vld;
  assign flush_step = (state == ST_FLUSH) && out_free;
  assign emit       = (fire && (state == ST_RUN)) || flush_step;

  assign bus.data_x_rdy = acc && bus.data_y_vld;
  assign bus.data_y_rdy = acc && bus.data_x_vld;
  assign busy           = (state != ST_IDLE);
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      p_prev2           <= 3'sb000;
      p_prev1           <= 3'sb000;
      bus.data_out      <= SD_ZERO;
      bus.data_out_vld  <= 1'b0;
      bus.data_out_last <= 1'b0;
    end else begin
      if (emit) begin
        bus.data_out      <= sd_encode(z_sum);
        bus.data_out_vld  <= 1'b1;
        bus.data_out_last <= (state == ST_FLUSH) && (cnt == CNT_END);
      end else if (bus.data_out_rdy) begin
        bus.data_out_vld  <= 1'b0;
        bus.data_out_last <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fire) begin
            p_prev2 <= 3'sb000;
            p_prev1 <= p_new;
            cnt     <= CNT_W'(1);
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire) begin
            p_prev2 <= p_prev1;
            p_prev1 <= p_new;
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_PRE_LAST) begin
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_step) begin
            if (cnt == CNT_END) begin
              p_prev2 <= 3'sb000;
              p_prev1 <= 3'sb000;
              cnt     <= '0;
              state   <= ST_IDLE;
            end else begin
              p_prev2 <= p_prev1;
              p_prev1 <= p_in;
              cnt     <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_online_adder_stream.sv
// Directed bench for online_adder_stream with DIGITS=4: hand-computed digit
// streams, backpressure, one-sided valid, back-to-back and mid-operation reset.
module tb_online_adder_stream;
  import online_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 3;

  logic   clk = 1'b0;
  logic   asyn_reset;
  logic   busy;
  state_e state_dbg;

  online_adder_stream_if bus ();

  online_adder_stream #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int first_vld_cyc = 0;
  logic vld_seen = 1'b0;
  int acc_cyc_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything sampled at negedge is what the next posedge transfers.
  always @(negedge clk) begin
    if (!asyn_reset) begin
      if (bus.data_x_vld && bus.data_x_rdy && bus.data_y_vld && bus.data_y_rdy) begin
        acc_cnt++;
        acc_cyc_q.push_back(cyc);
      end
      if (bus.data_out_vld && !vld_seen) begin
        vld_seen = 1'b1;
        first_vld_cyc = cyc;
      end
      if (bus.data_out_vld && bus.data_out_rdy) begin
        got_q.push_back({bus.data_out_last, bus.data_out});
        out_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    acc_cnt = 0;
    out_cnt = 0;
    vld_seen = 1'b0;
  endtask

  task automatic push_exp(input logic [9:0] zs);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({(k == 4), zs[9-2*k -: 2]});
    end
  endtask

  task automatic drive_pair(input logic [1:0] xd, input logic [1:0] yd);
    int guard;
    guard = 0;
    bus.x_in = xd;
    bus.y_in = yd;
    bus.data_x_vld = 1'b1;
    bus.data_y_vld = 1'b1;
    @(negedge clk);
    while (!(bus.data_x_rdy && bus.data_y_rdy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL pair_accept: rdy=%b%b after %0d cycles, required 11",
               bus.data_x_rdy, bus.data_y_rdy, guard);
    end
    @(posedge clk);
    #1;
    bus.data_x_vld = 1'b0;
    bus.data_y_vld = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] xs, input logic [7:0] ys);
    for (int j = 0; j < DIGITS; j++) begin
      drive_pair(xs[7-2*j -: 2], ys[7-2*j -: 2]);
    end
  endtask

  task automatic wait_outputs(input int n);
    int guard;
    guard = 0;
    while (out_cnt < n && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    bus.x_in = SD_POS;
    bus.y_in = SD_POS;
    bus.data_x_vld = 1'b1;
    bus.data_y_vld = 1'b1;
    bus.data_out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.data_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b, required 0", bus.data_out_vld); end
    checks++;
    if (bus.data_out !== 2'b00) begin errors++; $display("FAIL reset_data: got %b, required 00", bus.data_out); end
    checks++;
    if (bus.data_out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", bus.data_out_last); end
    checks++;
    if (bus.data_x_rdy !== 1'b0) begin errors++; $display("FAIL reset_x_rdy: got %b, required 0", bus.data_x_rdy); end
    checks++;
    if (bus.data_y_rdy !== 1'b0) begin errors++; $display("FAIL reset_y_rdy: got %b, required 0", bus.data_y_rdy); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE); end
    bus.data_x_vld = 1'b0;
    bus.data_y_vld = 1'b0;
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] e, g;
    int idx;
    clear_sb();
    bus.data_out_rdy = 1'b1;
    push_exp(10'b01_00_00_00_00);
    send_op(8'b01_00_00_00, 8'b01_00_00_00);
    wait_outputs(5);
    checks++;
    if (out_cnt != 5) begin errors++; $display("FAIL basic_count: got %0d, required 5", out_cnt); end
    checks++;
    if (acc_cyc_q.size() < 2 || first_vld_cyc != acc_cyc_q[1] + 1) begin
      errors++;
      $display("FAIL basic_latency: first vld cycle %0d, required %0d", first_vld_cyc,
               (acc_cyc_q.size() < 2) ? -1 : acc_cyc_q[1] + 1);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL basic_digit[%0d]: got {last,z}=%b, required %b", idx, g, e); end
      idx++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_value_one();
    logic [W-1:0] e, g;
    int idx;
    clear_sb();
    push_exp(10'b01_00_00_00_00);
    send_op(8'b01_01_01_01, 8'b00_00_00_01);
    wait_outputs(5);
    checks++;
    if (out_cnt != 5) begin errors++; $display("FAIL one_count: got %0d, required 5", out_cnt); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL one_digit[%0d]: got {last,z}=%b, required %b", idx, g, e); end
      idx++;
    end
  endtask

  task automatic test_small_and_redundant();
    logic [W-1:0] e, g;
    int idx;
    for (int v = 0; v < 2; v++) begin
      clear_sb();
      push_exp(10'b00_00_00_01_10);
      if (v == 0) send_op(8'b01_00_00_00, 8'b10_00_00_01);
      else        send_op(8'b01_00_00_00, 8'b10_11_11_01);
      wait_outputs(5);
      checks++;
      if (out_cnt != 5) begin errors++; $display("FAIL small_count[v%0d]: got %0d, required 5", v, out_cnt); end
      idx = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
        checks++;
        if (g !== e) begin errors++; $display("FAIL small_digit[v%0d][%0d]: got {last,z}=%b, required %b", v, idx, g, e); end
        idx++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e, g;
    int idx;
    clear_sb();
    bus.data_out_rdy = 1'b1;
    push_exp(10'b00_10_00_01_00);
    fork
      send_op(8'b00_10_00_00, 8'b00_00_10_00);
      begin
        int guard;
        guard = 0;
        while (out_cnt < 1 && guard < 100) begin
          @(posedge clk);
          guard++;
        end
        #1;
        bus.data_out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checks++;
          if (bus.data_out_vld !== 1'b1 || bus.data_out !== SD_NEG) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got vld=%b z=%b, required vld=1 z=10", c, bus.data_out_vld, bus.data_out);
          end
          checks++;
          if (bus.data_x_rdy !== 1'b0 || bus.data_y_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_rdy[%0d]: got x_rdy=%b y_rdy=%b, required 0 0", c, bus.data_x_rdy, bus.data_y_rdy);
          end
        end
        checks++;
        if (acc_cnt != 3) begin errors++; $display("FAIL bp_accepts: got %0d, required 3", acc_cnt); end
        @(posedge clk);
        #1;
        bus.data_out_rdy = 1'b1;
      end
    join
    wait_outputs(5);
    checks++;
    if (out_cnt != 5) begin errors++; $display("FAIL bp_count: got %0d, required 5", out_cnt); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL bp_digit[%0d]: got {last,z}=%b, required %b", idx, g, e); end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, g;
    int idx;
    clear_sb();
    bus.data_out_rdy = 1'b1;
    bus.x_in = SD_POS;
    bus.data_x_vld = 1'b1;
    bus.data_y_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.data_y_rdy !== 1'b1 || bus.data_x_rdy !== 1'b0) begin
        errors++;
        $display("FAIL one_sided_rdy[%0d]: got x_rdy=%b y_rdy=%b, required 0 1", c, bus.data_x_rdy, bus.data_y_rdy);
      end
    end
    checks++;
    if (acc_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_sided_consume: got accepts=%0d busy=%b, required 0 0", acc_cnt, busy);
    end
    @(posedge clk);
    #1;
    bus.data_x_vld = 1'b0;
    push_exp(10'b01_00_00_00_00);
    push_exp(10'b00_10_00_01_00);
    send_op(8'b01_01_01_01, 8'b00_00_00_01);
    send_op(8'b00_10_00_00, 8'b00_00_10_00);
    wait_outputs(10);
    checks++;
    if (out_cnt != 10) begin errors++; $display("FAIL b2b_count: got %0d, required 10", out_cnt); end
    checks++;
    if (acc_cnt != 8) begin errors++; $display("FAIL b2b_accepts: got %0d, required 8", acc_cnt); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_digit[%0d]: got {last,z}=%b, required %b", idx, g, e); end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e, g;
    int idx;
    clear_sb();
    bus.data_out_rdy = 1'b0;
    drive_pair(SD_POS, SD_NEG);
    drive_pair(SD_POS, SD_POS);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || state_dbg !== ST_RUN || bus.data_out_vld !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset: got busy=%b state=%0d vld=%b, required 1 %0d 1",
               busy, state_dbg, bus.data_out_vld, ST_RUN);
    end
    bus.data_x_vld = 1'b1;
    bus.data_y_vld = 1'b1;
    #2;
    asyn_reset = 1'b1;
    #1;
    checks++;
    if (bus.data_out_vld !== 1'b0 || bus.data_out_last !== 1'b0 || bus.data_out !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_out: got vld=%b last=%b z=%b, required 0 0 00",
               bus.data_out_vld, bus.data_out_last, bus.data_out);
    end
    checks++;
    if (busy !== 1'b0 || bus.data_x_rdy !== 1'b0 || bus.data_y_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ctl: got busy=%b x_rdy=%b y_rdy=%b, required 0 0 0",
               busy, bus.data_x_rdy, bus.data_y_rdy);
    end
    @(negedge clk);
    bus.data_x_vld = 1'b0;
    bus.data_y_vld = 1'b0;
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;
    clear_sb();
    bus.data_out_rdy = 1'b1;
    push_exp(10'b01_00_00_00_00);
    send_op(8'b01_00_00_00, 8'b01_00_00_00);
    wait_outputs(5);
    checks++;
    if (out_cnt != 5) begin errors++; $display("FAIL mid_count: got %0d, required 5", out_cnt); end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL mid_digit[%0d]: got {last,z}=%b, required %b", idx, g, e); end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_value_one();
    test_small_and_redundant();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
